wptr_full_ctrl: RTL and testbench

WPTR_FULL_CTRL -- requirements
Module: wptr_full_ctrl

---
 rtl/wptr_full_ctrl.sv | 88 ++++++++
 tb/tb_wptr_full_ctrl.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : wptr_full_ctrl
// Description : Async-FIFO write-side pointer, full/almost-full and level logic.
// Revision    : 1.0
// ============================================================================

module wptr_full_ctrl #(
    parameter int ADDRSIZE     = 4,
    parameter int AFULL_THRESH = 12
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                winc,
    input  logic [ADDRSIZE:0]   rptr_gray,
    input  logic                ovf_clr,
    output logic                wclken,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic                wfull,
    output logic                walmost_full,
    output logic [ADDRSIZE:0]   wlevel,
    output logic                woverflow
);

    localparam logic [ADDRSIZE:0] c_afull = AFULL_THRESH[ADDRSIZE:0];

    logic [ADDRSIZE:0] wq1_rptr;
    logic [ADDRSIZE:0] wq2_rptr;
    logic [ADDRSIZE:0] wbin;
    logic [ADDRSIZE:0] wbinnext;
    logic [ADDRSIZE:0] wgraynext;
    logic [ADDRSIZE:0] rbin_s;
    logic [ADDRSIZE:0] wlevel_next;
    logic [ADDRSIZE:0] wfull_match;
    logic              wfull_next;

    // Two-flop synchronizer for the read pointer crossing from the read domain.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wq1_rptr <= '0;
            wq2_rptr <= '0;
        end else begin
            wq1_rptr <= rptr_gray;
            wq2_rptr <= wq1_rptr;
        end
    end

    assign wclken    = winc & ~wfull;
    assign waddr     = wbin[ADDRSIZE-1:0];
    assign wbinnext  = wbin + {{ADDRSIZE{1'b0}}, wclken};
    assign wgraynext = (wbinnext >> 1) ^ wbinnext;

    always_comb begin
        rbin_s = '0;
        for (int i = 0; i <= ADDRSIZE; i++) begin
            rbin_s[i] = ^(wq2_rptr >> i);
        end
    end

    // Full when the write pointer is exactly one lap ahead of the read pointer.
    assign wfull_match = {~wq2_rptr[ADDRSIZE:ADDRSIZE-1], wq2_rptr[ADDRSIZE-2:0]};
    assign wfull_next  = (wgraynext == wfull_match);

    // Stale rbin_s can only make the level look higher, never lower.
    assign wlevel_next = wbinnext - rbin_s;

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            wbin         <= '0;
            wptr         <= '0;
            wfull        <= 1'b0;
            walmost_full <= 1'b0;
            wlevel       <= '0;
            woverflow    <= 1'b0;
        end else begin
            wbin         <= wbinnext;
            wptr         <= wgraynext;
            wfull        <= wfull_next;
            walmost_full <= (wlevel_next >= c_afull);
            wlevel       <= wlevel_next;
            woverflow    <= (winc & wfull) | (woverflow & ~ovf_clr);
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_wptr_full_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_wptr_full_ctrl
// Description : Directed self-checking bench for wptr_full_ctrl (ADDRSIZE=4).
// Revision    : 1.0
// ============================================================================

module tb_wptr_full_ctrl;

    localparam int ADDRSIZE     = 4;
    localparam int AFULL_THRESH = 12;

    logic                wclk;
    logic                wrst_n;
    logic                winc;
    logic [ADDRSIZE:0]   rptr_gray;
    logic                ovf_clr;
    logic                wclken;
    logic [ADDRSIZE-1:0] waddr;
    logic [ADDRSIZE:0]   wptr;
    logic                wfull;
    logic                walmost_full;
    logic [ADDRSIZE:0]   wlevel;
    logic                woverflow;

    int n_checks = 0;
    int n_pass   = 0;

    wptr_full_ctrl #(
        .ADDRSIZE     (ADDRSIZE),
        .AFULL_THRESH (AFULL_THRESH)
    ) dut (
        .wclk         (wclk),
        .wrst_n       (wrst_n),
        .winc         (winc),
        .rptr_gray    (rptr_gray),
        .ovf_clr      (ovf_clr),
        .wclken       (wclken),
        .waddr        (waddr),
        .wptr         (wptr),
        .wfull        (wfull),
        .walmost_full (walmost_full),
        .wlevel       (wlevel),
        .woverflow    (woverflow)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic [ADDRSIZE:0] to_gray(input logic [ADDRSIZE:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_waddr"}, 32'(waddr), 0);
        chk({tag, "_wptr"},  32'(wptr), 0);
        chk({tag, "_wfull"}, 32'(wfull), 0);
        chk({tag, "_afull"}, 32'(walmost_full), 0);
        chk({tag, "_wlevel"}, 32'(wlevel), 0);
        chk({tag, "_ovf"},   32'(woverflow), 0);
    endtask

    task automatic do_reset();
        winc      = 1'b0;
        ovf_clr   = 1'b0;
        rptr_gray = '0;
        wrst_n    = 1'b0;
        step();
        step();
        wrst_n    = 1'b1;
    endtask

    logic [ADDRSIZE:0] wb;
    logic [ADDRSIZE:0] prev_wptr;
    logic [ADDRSIZE:0] lag;

    initial begin
        wrst_n    = 1'b1;
        winc      = 1'b0;
        ovf_clr   = 1'b0;
        rptr_gray = '0;
        #1 wrst_n = 1'b0;
        #1;
        check_all_zero("rst_init");
        chk("rst_init_wclken", 32'(wclken), 0);
        step();
        step();
        wrst_n = 1'b1;

        // Fill: 16 accepted writes, then one rejected.
        for (int i = 0; i < 17; i++) begin
            winc = 1'b1;
            #1;
            chk("fill_wclken", 32'(wclken), (i < 16) ? 1 : 0);
            if (i < 16) chk("fill_waddr", 32'(waddr), 32'(i));
            step();
            if (i < 16) begin
                chk("fill_wlevel", 32'(wlevel), 32'(i + 1));
                chk("fill_afull", 32'(walmost_full), (i + 1 >= 12) ? 1 : 0);
                chk("fill_wfull", 32'(wfull), (i + 1 == 16) ? 1 : 0);
            end
        end
        winc = 1'b0;
        chk("ovf_set", 32'(woverflow), 1);
        chk("rej_wptr", 32'(wptr), 32'h18);
        chk("rej_waddr", 32'(waddr), 0);
        chk("rej_wlevel", 32'(wlevel), 16);

        // Overflow clear, then set-wins when both happen together.
        ovf_clr = 1'b1;
        step();
        chk("ovf_clr", 32'(woverflow), 0);
        ovf_clr = 1'b0;
        step();
        chk("ovf_hold_clr", 32'(woverflow), 0);
        winc    = 1'b1;
        ovf_clr = 1'b1;
        step();
        chk("ovf_set_wins", 32'(woverflow), 1);
        chk("ovf_wptr_kept", 32'(wptr), 32'h18);
        winc    = 1'b0;
        ovf_clr = 1'b0;

        // Read pointer moves to binary 4, then 5; three-edge latency.
        rptr_gray = 5'b00110;
        step();
        step();
        chk("rd4_wfull_lat2", 32'(wfull), 1);
        chk("rd4_wlevel_lat2", 32'(wlevel), 16);
        step();
        chk("rd4_wfull", 32'(wfull), 0);
        chk("rd4_wlevel", 32'(wlevel), 12);
        chk("rd4_afull", 32'(walmost_full), 1);
        rptr_gray = 5'b00111;
        step();
        step();
        step();
        chk("rd5_wlevel", 32'(wlevel), 11);
        chk("rd5_afull", 32'(walmost_full), 0);
        chk("rd5_wfull", 32'(wfull), 0);

        // Wrap: 40 writes with the read pointer two behind.
        do_reset();
        wb = '0;
        for (int i = 0; i < 40; i++) begin
            lag       = (wb >= 2) ? wb - 2 : '0;
            rptr_gray = to_gray(lag);
            winc      = 1'b1;
            prev_wptr = wptr;
            step();
            wb = wb + 1;
            chk("wrap_wptr", 32'(wptr), 32'(to_gray(wb)));
            chk("wrap_onebit", 32'($countones(prev_wptr ^ wptr)), 1);
            chk("wrap_wfull", 32'(wfull), 0);
            chk("wrap_waddr", 32'(waddr), 32'(wb[ADDRSIZE-1:0]));
        end
        winc = 1'b0;

        // Asynchronous reset with 9 entries stored and no clock edge.
        do_reset();
        winc = 1'b1;
        repeat (9) step();
        winc = 1'b0;
        chk("pre_arst_wlevel", 32'(wlevel), 9);
        #1 wrst_n = 1'b0;
        #1;
        check_all_zero("arst");
        chk("arst_wclken", 32'(wclken), 0);
        #1 wrst_n = 1'b1;
        winc = 1'b1;
        #1;
        chk("post_arst_waddr", 32'(waddr), 0);
        chk("post_arst_wclken", 32'(wclken), 1);
        step();
        winc = 1'b0;
        chk("post_arst_waddr1", 32'(waddr), 1);
        chk("post_arst_wlevel", 32'(wlevel), 1);
        chk("post_arst_wptr", 32'(wptr), 1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
